alu_issue_ctrl: RTL

Command buffer and issue sequencer upstream of the 4-bit ALU. Accepts operand/opcode commands over a valid/ready handshake into a small FIFO. Issues one command at a time to the ALU through registered operand outputs and captures the ALU's 9-bit result into a result register. That register is drained by a valid/ready consumer, so a stalled consumer back-pressures the command queue.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_if.sv | 68 ++++++
 rtl/alu_cmd_fifo.sv | 61 ++++++
 rtl/alu_issue_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: opcode encoding, operand/result widths,
// the queued command record and the issue sequencer states.
package alu_pkg;

    localparam int unsigned ALU_W     = 4;
    localparam int unsigned ALU_RES_W = 9;
    localparam int unsigned ALU_OP_W  = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_OR  = 3'd4,
        ALU_ROL = 3'd5,
        ALU_ROR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e          op;
        logic [ALU_W-1:0] in1;
        logic [ALU_W-1:0] in2;
    } alu_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and result channels of alu_issue_ctrl.
// With ALU_ISSUE_FLAGS_EN defined the result channel also carries res_zero/res_wide.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ALU_W-1:0]     cmd_in1;
    logic [ALU_W-1:0]     cmd_in2;
    logic [ALU_OP_W-1:0]  cmd_op;

    logic [ALU_W-1:0]     alu_in1;
    logic [ALU_W-1:0]     alu_in2;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [ALU_RES_W-1:0] alu_result;

    logic                 res_valid;
    logic                 res_ready;
    logic [ALU_RES_W-1:0] res_data;
    logic [ALU_OP_W-1:0]  res_op;
`ifdef ALU_ISSUE_FLAGS_EN
    logic                 res_zero;
    logic                 res_wide;
`endif

    // Issue controller side.
    modport slave (
`ifdef ALU_ISSUE_FLAGS_EN
        output res_zero,
        output res_wide,
`endif
        input  cmd_valid,
        output cmd_ready,
        input  cmd_in1,
        input  cmd_in2,
        input  cmd_op,
        output alu_in1,
        output alu_in2,
        output alu_op,
        input  alu_result,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_op
    );

    // Producer / ALU / consumer side.
    modport master (
`ifdef ALU_ISSUE_FLAGS_EN
        input  res_zero,
        input  res_wide,
`endif
        output cmd_valid,
        input  cmd_ready,
        output cmd_in1,
        output cmd_in2,
        output cmd_op,
        input  alu_in1,
        input  alu_in2,
        input  alu_op,
        output alu_result,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_op
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with flush. DEPTH must be a power of two so the
// pointers wrap for free; level counts 0..DEPTH.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  alu_cmd_t                 wdata,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointer and occupancy tracking; flush discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command buffer and issue sequencer for the 4-bit ALU. Commands queue in
// alu_cmd_fifo; a two-state sequencer drives registered ALU operands and then
// captures the ALU result into a valid/ready result register.
// Optional: ALU_ISSUE_FLAGS_EN adds registered res_zero/res_wide outputs.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    alu_issue_ctrl_if.slave        bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    issue_state_e         state_q;
    logic [ALU_W-1:0]     alu_in1_q;
    logic [ALU_W-1:0]     alu_in2_q;
    alu_op_e              alu_op_q;
    logic                 res_valid_q;
    logic [ALU_RES_W-1:0] res_data_q;
    logic [ALU_OP_W-1:0]  res_op_q;
`ifdef ALU_ISSUE_FLAGS_EN
    logic                 res_zero_q;
    logic                 res_wide_q;
`endif

    logic     push;
    logic     pop;
    logic     full;
    logic     empty;
    alu_cmd_t wcmd;
    alu_cmd_t head;

    assign wcmd = '{op: alu_op_e'(bus.cmd_op), in1: bus.cmd_in1, in2: bus.cmd_in2};

    assign bus.cmd_ready = !full && !flush;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // Only issue when the result register will be free by the time EXEC captures.
    assign pop  = (state_q == IDLE) && !empty && (!res_valid_q || bus.res_ready) && !flush;
    assign busy = !empty || (state_q == EXEC);

    assign bus.alu_in1   = alu_in1_q;
    assign bus.alu_in2   = alu_in2_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
`ifdef ALU_ISSUE_FLAGS_EN
    assign bus.res_zero  = res_zero_q;
    assign bus.res_wide  = res_wide_q;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Issue sequencer plus result register; a capture in EXEC beats a same-edge drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= ALU_ADD;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            res_zero_q  <= 1'b0;
            res_wide_q  <= 1'b0;
`endif
        end else begin
            if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (pop) begin
                            alu_in1_q <= head.in1;
                            alu_in2_q <= head.in2;
                            alu_op_q  <= head.op;
                            state_q   <= EXEC;
                        end
                    end
                    EXEC: begin
                        res_data_q  <= bus.alu_result;
                        res_op_q    <= alu_op_q;
                        res_valid_q <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                        res_zero_q  <= (bus.alu_result == '0);
                        res_wide_q  <= |bus.alu_result[ALU_RES_W-1:ALU_W];
`endif
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
